// File: rtl/spacing_fn_lanes.sv
// spacing_fn_lanes: maps LANES ray distances t to signed sample coordinate s.
// Linear s ~ (t - near); disparity s ~ (1/near - 1/t) via one serial divider.
// Ports: clk, rst (async, active high);
//   i_valid/i_ready/i_data: input beat, lane 0 in the LSBs;
//   cfg_mode/cfg_near/cfg_inv_near/cfg_scale: captured with each beat;
//   o_valid/o_ready/o_data: output beat; o_sat: per-lane clip flag.
module spacing_fn_lanes #(
   parameter int LANES    = 4,
   parameter int IN_W     = 21,
   parameter int OUT_W    = 13,
   parameter int CFG_W    = 16,
   parameter int SCALE_SH = 16,
   parameter int RCP_SH   = 30
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [LANES*IN_W-1:0]  i_data,
   input  logic                   cfg_mode,
   input  logic [IN_W-1:0]        cfg_near,
   input  logic [IN_W-1:0]        cfg_inv_near,
   input  logic [CFG_W-1:0]       cfg_scale,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [LANES*OUT_W-1:0] o_data,
   output logic [LANES-1:0]       o_sat
);
   localparam int PW = IN_W + CFG_W + 2;
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int BW = $clog2(IN_W);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] DIV  = 1'b1;
   // Starting remainder: the quotient bits above IN_W are zero for t > RINIT.
   localparam logic [IN_W-1:0] RINIT = IN_W'(1) << (RCP_SH - IN_W);
   localparam logic signed [PW-1:0] SMAX = PW'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [PW-1:0] SMIN = ~SMAX;

   logic [0:0]           state;
   logic [IN_W-1:0]      cap_t [LANES];
   logic [IN_W-1:0]      cap_inv;
   logic [CFG_W-1:0]     cap_scale;
   logic [IN_W-1:0]      rcp [LANES];
   logic [IN_W-1:0]      rcp_nx [LANES];
   logic [IN_W-1:0]      rem;
   logic [IN_W-2:0]      q;
   logic [LW-1:0]        lane;
   logic [BW-1:0]        bitc;
   logic                 div_done;
   logic                 s1_valid;
   logic signed [PW-1:0] s1_p [LANES];
   logic signed [PW-1:0] p_nx [LANES];
   logic signed [IN_W:0] d [LANES];
   logic signed [PW-1:0] sh [LANES];
   logic [OUT_W-1:0]     s_nx [LANES];
   logic [LANES-1:0]     sat_nx;
   logic                 s2_en, s1_free, acc, ge;
   logic                 stepping, lane_end, last, div_fin, ld;
   logic [IN_W-1:0]      cur_t, diff, rem_nx, lane_r;
   logic [IN_W:0]        rem_sh;
   logic [CFG_W-1:0]     sc;

   always_comb begin
      s2_en   = !o_valid || o_ready;
      s1_free = !s1_valid || s2_en;
      i_ready = (state == IDLE) && s1_free;
      acc     = i_valid && i_ready;
   end

   // One restoring-division step per cycle on the current lane.
   always_comb begin
      cur_t    = cap_t[lane];
      rem_sh   = {rem, 1'b0};
      diff     = rem_sh[IN_W-1:0] - cur_t;
      ge       = rem_sh >= {1'b0, cur_t};
      rem_nx   = ge ? diff : rem_sh[IN_W-1:0];
      lane_r   = (cur_t <= RINIT) ? '1 : {q, ge};
      lane_end = bitc == BW'(IN_W - 1);
      last     = lane_end && (lane == LW'(LANES - 1));
      stepping = (state == DIV) && !div_done;
      div_fin  = (state == DIV) && (div_done || last) && s1_free;
      ld       = (acc && !cfg_mode) || div_fin;
      for (int k = 0; k < LANES; k++) rcp_nx[k] = rcp[k];
      if (stepping && lane_end) rcp_nx[lane] = lane_r;
   end

   // Stage1 operand select: a finishing disparity beat has priority,
   // since i_ready is low while in DIV.
   always_comb begin
      sc = div_fin ? cap_scale : cfg_scale;
      for (int k = 0; k < LANES; k++) begin
         if (div_fin)
            d[k] = $signed({1'b0, cap_inv}) - $signed({1'b0, rcp_nx[k]});
         else
            d[k] = $signed({1'b0, i_data[k*IN_W +: IN_W]})
                 - $signed({1'b0, cfg_near});
         p_nx[k] = PW'(d[k]) * PW'($signed({1'b0, sc}));
      end
   end

   always_comb begin
      sat_nx = '0;
      for (int k = 0; k < LANES; k++) begin
         sh[k]   = s1_p[k] >>> SCALE_SH;
         s_nx[k] = sh[k][OUT_W-1:0];
         if (sh[k] > SMAX) begin
            s_nx[k]   = SMAX[OUT_W-1:0];
            sat_nx[k] = 1'b1;
         end else if (sh[k] < SMIN) begin
            s_nx[k]   = SMIN[OUT_W-1:0];
            sat_nx[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lane      <= '0;
         bitc      <= '0;
         rem       <= '0;
         q         <= '0;
         div_done  <= 1'b0;
         cap_inv   <= '0;
         cap_scale <= '0;
         for (int k = 0; k < LANES; k++) begin
            cap_t[k] <= '0;
            rcp[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < LANES; k++) rcp[k] <= rcp_nx[k];
         unique case (state)
            IDLE: begin
               if (acc && cfg_mode) begin
                  state     <= DIV;
                  lane      <= '0;
                  bitc      <= '0;
                  rem       <= RINIT;
                  div_done  <= 1'b0;
                  cap_inv   <= cfg_inv_near;
                  cap_scale <= cfg_scale;
                  for (int k = 0; k < LANES; k++)
                     cap_t[k] <= i_data[k*IN_W +: IN_W];
               end
            end
            DIV: begin
               if (stepping) begin
                  q <= {q[IN_W-3:0], ge};
                  if (lane_end) begin
                     bitc <= '0;
                     rem  <= RINIT;
                     lane <= lane + LW'(1);
                     // All lanes done but stage1 busy: park here.
                     if (last && !s1_free) div_done <= 1'b1;
                  end else begin
                     bitc <= bitc + BW'(1);
                     rem  <= rem_nx;
                  end
               end
               if (div_fin) begin
                  state    <= IDLE;
                  div_done <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         for (int k = 0; k < LANES; k++) s1_p[k] <= '0;
         o_valid  <= 1'b0;
         o_data   <= '0;
         o_sat    <= '0;
      end else begin
         if (s1_free) begin
            s1_valid <= ld;
            for (int k = 0; k < LANES; k++) s1_p[k] <= p_nx[k];
         end
         if (s2_en) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
               for (int k = 0; k < LANES; k++)
                  o_data[k*OUT_W +: OUT_W] <= s_nx[k];
               o_sat <= sat_nx;
            end
         end
      end
   end
endmodule
